// File: rtl/key_search_ctrl.sv
// Key search controller: walks the keygen candidate stream through an external
// AES-128 core and stops on a ciphertext match, keygen exhaustion or timeout.
module key_search_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic [127:0]     target,
    input  logic [127:0]     kg_key,
    input  logic             kg_done,
    output logic             kg_ena,
    output logic [127:0]     aes_key,
    output logic             aes_start,
    input  logic             aes_done,
    input  logic [127:0]     aes_result,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic             error,
    output logic [127:0]     key_out,
    output logic [CNT_W-1:0] try_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_ADVANCE = 3'd4,
        S_FOUND   = 3'd5,
        S_EXHAUST = 3'd6,
        S_ERROR   = 3'd7
    } state_t;

    function automatic logic key_match(input logic [127:0] a, input logic [127:0] b);
        return (a == b);
    endfunction

    state_t            state_q, state_d;
    logic [127:0]      cand_q, cand_d;
    logic [127:0]      key_out_q, key_out_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [CNT_W-1:0]  try_q, try_d;
    logic              found_q, found_d;
    logic              exh_q, exh_d;
    logic              err_q, err_d;
    logic              kg_ena_q, kg_ena_d;
    logic              aes_start_q, aes_start_d;
    logic              busy_q, busy_d;

    // Next-state and datapath update; abort overrides every state.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        key_out_d = key_out_q;
        tmo_d     = tmo_q;
        try_d     = try_q;
        found_d   = found_q;
        exh_d     = exh_q;
        err_d     = err_q;
        if (abort) begin
            state_d   = S_IDLE;
            found_d   = 1'b0;
            exh_d     = 1'b0;
            err_d     = 1'b0;
            key_out_d = 128'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_d   = S_LOAD;
                        try_d     = {CNT_W{1'b0}};
                        found_d   = 1'b0;
                        exh_d     = 1'b0;
                        err_d     = 1'b0;
                        key_out_d = 128'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (kg_done) begin
                        state_d = S_EXHAUST;
                        exh_d   = 1'b1;
                    end else begin
                        cand_d  = kg_key;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    tmo_d   = TW'(TIMEOUT);
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // A done in the expiry cycle still counts as an answer.
                    if (aes_done) begin
                        if (key_match(aes_result, target)) begin
                            key_out_d = cand_q;
                            found_d   = 1'b1;
                            state_d   = S_FOUND;
                        end else begin
                            state_d = S_ADVANCE;
                        end
                    end else if (tmo_q == TW'(1)) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        tmo_d = tmo_q - TW'(1);
                    end
                end
                S_ADVANCE: begin
                    if (try_q != {CNT_W{1'b1}}) begin
                        try_d = try_q + CNT_W'(1);
                    end else begin
                        try_d = try_q;
                    end
                    state_d = S_LOAD;
                end
                S_FOUND, S_EXHAUST, S_ERROR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Strobes and busy are registered decodes of the next state.
    always_comb begin
        kg_ena_d    = (state_d == S_ADVANCE);
        aes_start_d = (state_d == S_START);
        busy_d      = (state_d == S_LOAD) || (state_d == S_START) ||
                      (state_d == S_WAIT) || (state_d == S_ADVANCE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cand_q      <= 128'd0;
            key_out_q   <= 128'd0;
            tmo_q       <= {TW{1'b0}};
            try_q       <= {CNT_W{1'b0}};
            found_q     <= 1'b0;
            exh_q       <= 1'b0;
            err_q       <= 1'b0;
            kg_ena_q    <= 1'b0;
            aes_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            key_out_q   <= key_out_d;
            tmo_q       <= tmo_d;
            try_q       <= try_d;
            found_q     <= found_d;
            exh_q       <= exh_d;
            err_q       <= err_d;
            kg_ena_q    <= kg_ena_d;
            aes_start_q <= aes_start_d;
            busy_q      <= busy_d;
        end
    end

    assign kg_ena    = kg_ena_q;
    assign aes_start = aes_start_q;
    assign aes_key   = cand_q;
    assign busy      = busy_q;
    assign found     = found_q;
    assign exhausted = exh_q;
    assign error     = err_q;
    assign key_out   = key_out_q;
    assign try_cnt   = try_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Directed bench for key_search_ctrl: a wide instance (A) and a narrow
// CNT_W=4 / TIMEOUT=4 instance (B) share inputs; sel picks which one drives the models.
module tb_key_search_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         go = 1'b0;
    logic         abort = 1'b0;
    logic [127:0] target = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
    logic [127:0] kg_key;
    logic         kg_done;
    logic         aes_done;
    logic [127:0] aes_result;

    logic         a_kg_ena, a_aes_start, a_busy, a_found, a_exh, a_err;
    logic [127:0] a_aes_key, a_key_out;
    logic [31:0]  a_try_cnt;
    logic         b_kg_ena, b_aes_start, b_busy, b_found, b_exh, b_err;
    logic [127:0] b_aes_key, b_key_out;
    logic [3:0]   b_try_cnt;

    logic         sel = 1'b0;
    logic         tb_clr = 1'b0;
    logic         model_en = 1'b0;
    logic         force_done = 1'b0;
    logic [127:0] match_key = 128'd0;
    int           lat = 5;
    int           kg_limit = 100;
    int           kg_idx = 0;
    int           c_cnt = 0;
    logic [127:0] c_key = 128'd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    key_search_ctrl #(.CNT_W(32), .TIMEOUT(64)) dut_a (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .target(target),
        .kg_key(kg_key), .kg_done(kg_done), .kg_ena(a_kg_ena), .aes_key(a_aes_key),
        .aes_start(a_aes_start), .aes_done(aes_done), .aes_result(aes_result),
        .busy(a_busy), .found(a_found), .exhausted(a_exh), .error(a_err),
        .key_out(a_key_out), .try_cnt(a_try_cnt)
    );

    key_search_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .target(target),
        .kg_key(kg_key), .kg_done(kg_done), .kg_ena(b_kg_ena), .aes_key(b_aes_key),
        .aes_start(b_aes_start), .aes_done(aes_done), .aes_result(aes_result),
        .busy(b_busy), .found(b_found), .exhausted(b_exh), .error(b_err),
        .key_out(b_key_out), .try_cnt(b_try_cnt)
    );

    function automatic logic [127:0] key_of(input int i);
        return {32'h1111_0000 + i, 32'h2222_0000 + i, 32'h3333_0000 + i, 32'h4444_0000 + i};
    endfunction

    wire          kg_ena_sel    = sel ? b_kg_ena    : a_kg_ena;
    wire          aes_start_sel = sel ? b_aes_start : a_aes_start;
    wire [127:0]  aes_key_sel   = sel ? b_aes_key   : a_aes_key;

    assign kg_key     = key_of(kg_idx);
    assign kg_done    = (kg_idx >= kg_limit);
    assign aes_done   = (model_en && c_cnt == 1) || force_done;
    assign aes_result = (force_done || c_key == match_key) ? target : ~target;

    always @(posedge clk) begin
        if (tb_clr) kg_idx <= 0;
        else if (kg_ena_sel) kg_idx <= kg_idx + 1;
    end

    always @(posedge clk) begin
        if (tb_clr) c_cnt <= 0;
        else if (aes_start_sel) begin
            c_cnt <= lat;
            c_key <= aes_key_sel;
        end else if (c_cnt != 0) c_cnt <= c_cnt - 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_search();
        abort = 1'b1; tb_clr = 1'b1;
        tick();
        abort = 1'b0; tb_clr = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #11;
        checks++;
        if ({a_busy, a_found, a_exh, a_err, a_kg_ena, a_aes_start} !== 6'b0) begin
            errors++; $display("FAIL reset_flags_a: got %b want 000000", {a_busy, a_found, a_exh, a_err, a_kg_ena, a_aes_start});
        end
        checks++;
        if ({a_aes_key, a_key_out, a_try_cnt} !== 288'd0) begin
            errors++; $display("FAIL reset_data_a: got %h want 0", {a_aes_key, a_key_out, a_try_cnt});
        end
        checks++;
        if ({b_busy, b_found, b_exh, b_err, b_try_cnt} !== 8'd0) begin
            errors++; $display("FAIL reset_b: got %h want 0", {b_busy, b_found, b_exh, b_err, b_try_cnt});
        end
        @(negedge clk) rst = 1'b0;
        tick();
    endtask

    task automatic test_match();
        int starts = 0, enas = 0, first_start = -1, miss_cyc = -1, gap = -1;
        int hit_cyc = -1, found_cyc = -1;
        sel = 1'b0; model_en = 1'b1; lat = 5; match_key = key_of(2); kg_limit = 100;
        reset_search();
        go = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            tick();
            go = 1'b0;
            if (a_aes_start) begin
                starts++;
                if (first_start < 0) first_start = cyc;
                if (miss_cyc >= 0 && gap < 0) gap = cyc - miss_cyc;
            end
            if (a_kg_ena) enas++;
            if (a_found && found_cyc < 0) found_cyc = cyc;
            if (aes_done && aes_result !== target && miss_cyc < 0) miss_cyc = cyc;
            if (aes_done && aes_result === target) hit_cyc = cyc;
            if (found_cyc >= 0) break;
        end
        checks++;
        if (a_found !== 1'b1) begin errors++; $display("FAIL t1_found: got %b want 1", a_found); end
        checks++;
        if (a_key_out !== key_of(2)) begin errors++; $display("FAIL t1_key_out: got %h want %h", a_key_out, key_of(2)); end
        checks++;
        if (a_try_cnt !== 32'd2) begin errors++; $display("FAIL t1_try_cnt: got %0d want 2", a_try_cnt); end
        checks++;
        if (enas !== 2) begin errors++; $display("FAIL t1_kg_ena_pulses: got %0d want 2", enas); end
        checks++;
        if (starts !== 3) begin errors++; $display("FAIL t1_aes_start_pulses: got %0d want 3", starts); end
        checks++;
        if (first_start !== 2) begin errors++; $display("FAIL t1_go_to_start: got %0d want 2", first_start); end
        checks++;
        if (gap !== 3) begin errors++; $display("FAIL t1_miss_to_start: got %0d want 3", gap); end
        checks++;
        if (found_cyc - hit_cyc !== 1) begin errors++; $display("FAIL t1_hit_to_found: got %0d want 1", found_cyc - hit_cyc); end
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL t1_busy: got %b want 0", a_busy); end
    endtask

    task automatic test_exhaust();
        int starts = 0;
        sel = 1'b0; model_en = 1'b1; kg_limit = 0;
        reset_search();
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (a_exh !== 1'b0) begin errors++; $display("FAIL t2_exh_early: got %b want 0", a_exh); end
        tick();
        checks++;
        if (a_exh !== 1'b1) begin errors++; $display("FAIL t2_exh: got %b want 1", a_exh); end
        for (int i = 0; i < 6; i++) begin
            if (a_aes_start) starts++;
            tick();
        end
        checks++;
        if (starts !== 0) begin errors++; $display("FAIL t2_no_start: got %0d want 0", starts); end
        checks++;
        if (a_try_cnt !== 32'd0) begin errors++; $display("FAIL t2_try_cnt: got %0d want 0", a_try_cnt); end
        kg_limit = 100;
    endtask

    task automatic test_timeout();
        int enas = 0;
        sel = 1'b1; model_en = 1'b0; kg_limit = 100;
        reset_search();
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
        checks++;
        if (b_aes_start !== 1'b1) begin errors++; $display("FAIL t3_start: got %b want 1", b_aes_start); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (b_kg_ena) enas++;
        end
        checks++;
        if (b_err !== 1'b0) begin errors++; $display("FAIL t3_err_early: got %b want 0", b_err); end
        tick();
        checks++;
        if (b_err !== 1'b1 || b_busy !== 1'b0) begin
            errors++; $display("FAIL t3_error: got err=%b busy=%b want err=1 busy=0", b_err, b_busy);
        end
        for (int i = 0; i < 4; i++) begin
            if (b_kg_ena) enas++;
            tick();
        end
        checks++;
        if (enas !== 0) begin errors++; $display("FAIL t3_no_kg_ena: got %0d want 0", enas); end
    endtask

    task automatic test_abort();
        int starts = 0;
        sel = 1'b0; model_en = 1'b1; lat = 3; match_key = key_of(99); kg_limit = 100;
        reset_search();
        go = 1'b1;
        for (int cyc = 0; cyc < 60 && starts < 2; cyc++) begin
            tick();
            go = 1'b0;
            if (a_aes_start) starts++;
        end
        checks++;
        if (starts !== 2) begin errors++; $display("FAIL t4_reach_wait: got %0d starts want 2", starts); end
        tick(); tick();
        checks++;
        if (a_busy !== 1'b1 || a_try_cnt !== 32'd1) begin
            errors++; $display("FAIL t4_in_wait: got busy=%b try=%0d want busy=1 try=1", a_busy, a_try_cnt);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (a_busy !== 1'b0 || a_found !== 1'b0 || a_try_cnt !== 32'd1) begin
            errors++; $display("FAIL t4_aborted: got busy=%b found=%b try=%0d want 0 0 1", a_busy, a_found, a_try_cnt);
        end
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        tick();
        checks++;
        if (a_found !== 1'b0 || a_busy !== 1'b0) begin
            errors++; $display("FAIL t4_late_done: got found=%b busy=%b want 0 0", a_found, a_busy);
        end
        go = 1'b1;
        tick();
        go = 1'b0;
        checks++;
        if (a_try_cnt !== 32'd0 || a_busy !== 1'b1) begin
            errors++; $display("FAIL t4_restart: got try=%0d busy=%b want 0 1", a_try_cnt, a_busy);
        end
        reset_search();
    endtask

    task automatic test_async_reset();
        sel = 1'b0; model_en = 1'b0;
        reset_search();
        go = 1'b1;
        tick();
        go = 1'b0;
        tick(); tick();
        checks++;
        if (a_busy !== 1'b1 || a_aes_key !== key_of(0)) begin
            errors++; $display("FAIL t5_wait: got busy=%b key=%h want 1 %h", a_busy, a_aes_key, key_of(0));
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_busy, a_found, a_exh, a_err, a_kg_ena, a_aes_start} !== 6'b0) begin
            errors++; $display("FAIL t5_flags: got %b want 000000", {a_busy, a_found, a_exh, a_err, a_kg_ena, a_aes_start});
        end
        checks++;
        if ({a_aes_key, a_key_out, a_try_cnt} !== 288'd0) begin
            errors++; $display("FAIL t5_data: got %h want 0", {a_aes_key, a_key_out, a_try_cnt});
        end
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        int starts = 0;
        logic seen_sat = 1'b0;
        sel = 1'b1; model_en = 1'b1; lat = 1; match_key = key_of(20); kg_limit = 100;
        reset_search();
        go = 1'b1;
        for (int cyc = 0; cyc < 400 && !b_found; cyc++) begin
            tick();
            go = 1'b0;
            if (b_aes_start) begin
                starts++;
                if (starts == 18) seen_sat = (b_try_cnt === 4'd15) && b_busy;
            end
        end
        checks++;
        if (seen_sat !== 1'b1) begin errors++; $display("FAIL t6_sat_midway: got %b want 1", seen_sat); end
        checks++;
        if (b_found !== 1'b1 || b_try_cnt !== 4'd15) begin
            errors++; $display("FAIL t6_final: got found=%b try=%0d want 1 15", b_found, b_try_cnt);
        end
        checks++;
        if (starts !== 21 || b_key_out !== key_of(20)) begin
            errors++; $display("FAIL t6_key: got starts=%0d key=%h want 21 %h", starts, b_key_out, key_of(20));
        end
    endtask

    initial begin
        test_reset();
        test_match();
        test_exhaust();
        test_timeout();
        test_abort();
        test_async_reset();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
